// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing generator: qualifies the PLL lock, then emits registered syncs, DE and coordinates.
// Optional NES 256x240 2x window outputs are enabled by defining VGA_NES_WINDOW_EN.
module vga_timing_gen #(
  parameter int H_ACTIVE      = 640,
  parameter int H_FRONT       = 16,
  parameter int H_SYNC        = 96,
  parameter int H_BACK        = 48,
  parameter int V_ACTIVE      = 480,
  parameter int V_FRONT       = 10,
  parameter int V_SYNC        = 2,
  parameter int V_BACK        = 33,
  parameter bit SYNC_POL      = 1'b0,
  parameter int SETTLE_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_locked,
  output logic       hsync,
  output logic       vsync,
  output logic       de,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       line_start,
  output logic       frame_start,
  output logic       running
`ifdef VGA_NES_WINDOW_EN
  ,
  output logic       nes_de,
  output logic [7:0] nes_x,
  output logic [7:0] nes_y
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0]  H_LAST      = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST      = 10'(V_TOTAL - 1);
  localparam logic [9:0]  H_ACT       = 10'(H_ACTIVE);
  localparam logic [9:0]  V_ACT       = 10'(V_ACTIVE);
  localparam logic [9:0]  HS_START    = 10'(H_ACTIVE + H_FRONT);
  localparam logic [9:0]  HS_END      = 10'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [9:0]  VS_START    = 10'(V_ACTIVE + V_FRONT);
  localparam logic [9:0]  VS_END      = 10'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_SETTLE    = 2'd1,
    ST_RUN       = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        sync1_q, lock_s_q;
  logic [15:0] settle_q, settle_d;
  logic [9:0]  h_q, h_d, v_q, v_d;

  logic       hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
  logic [9:0] x_q, x_d, y_q, y_d;
  logic       line_start_q, line_start_d, frame_start_q, frame_start_d;
  logic       running_q, running_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      lock_s_q <= 1'b0;
    end else begin
      sync1_q  <= pll_locked;
      lock_s_q <= sync1_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_WAIT_LOCK;
      settle_q <= 16'd0;
      h_q      <= 10'd0;
      v_q      <= 10'd0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      h_q      <= h_d;
      v_q      <= v_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_WAIT_LOCK: if (lock_s_q) state_d = ST_SETTLE;
      ST_SETTLE: begin
        if (!lock_s_q)                   state_d = ST_WAIT_LOCK;
        else if (settle_q == SETTLE_LAST) state_d = ST_RUN;
      end
      ST_RUN:       if (!lock_s_q) state_d = ST_WAIT_LOCK;
      default:      state_d = ST_WAIT_LOCK;
    endcase
  end

  // Counters only run while staying in a state; any exit or entry restarts them from 0.
  always_comb begin
    settle_d = 16'd0;
    h_d      = 10'd0;
    v_d      = 10'd0;
    if (state_q == ST_SETTLE && state_d == ST_SETTLE) begin
      settle_d = settle_q + 16'd1;
    end
    if (state_q == ST_RUN && state_d == ST_RUN) begin
      if (h_q == H_LAST) begin
        h_d = 10'd0;
        v_d = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
        v_d = v_q;
      end
    end
  end

  always_comb begin
    hsync_d       = ~SYNC_POL;
    vsync_d       = ~SYNC_POL;
    de_d          = 1'b0;
    x_d           = 10'd0;
    y_d           = 10'd0;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    running_d     = (state_d == ST_RUN);
    if (state_q == ST_RUN) begin
      de_d = (h_q < H_ACT) && (v_q < V_ACT);
      if (h_q >= HS_START && h_q < HS_END) hsync_d = SYNC_POL;
      if (v_q >= VS_START && v_q < VS_END) vsync_d = SYNC_POL;
      if (de_d) begin
        x_d = h_q;
        y_d = v_q;
      end
      line_start_d  = (h_q == 10'd0) && (v_q < V_ACT);
      frame_start_d = (h_q == 10'd0) && (v_q == 10'd0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      de_q          <= 1'b0;
      x_q           <= 10'd0;
      y_q           <= 10'd0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      running_q     <= 1'b0;
    end else begin
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      x_q           <= x_d;
      y_q           <= y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      running_q     <= running_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign x           = x_q;
  assign y           = y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign running     = running_q;

`ifdef VGA_NES_WINDOW_EN
  logic       nes_de_q, nes_de_d;
  logic [7:0] nes_x_q, nes_x_d, nes_y_q, nes_y_d;

  // Centred 512-pixel window, each NES pixel doubled in both directions.
  always_comb begin
    nes_de_d = de_d && (h_q >= 10'd64) && (h_q < 10'd576);
    nes_x_d  = nes_de_d ? 8'((h_q - 10'd64) >> 1) : 8'd0;
    nes_y_d  = nes_de_d ? v_q[8:1] : 8'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nes_de_q <= 1'b0;
      nes_x_q  <= 8'd0;
      nes_y_q  <= 8'd0;
    end else begin
      nes_de_q <= nes_de_d;
      nes_x_q  <= nes_x_d;
      nes_y_q  <= nes_y_d;
    end
  end

  assign nes_de = nes_de_q;
  assign nes_x  = nes_x_q;
  assign nes_y  = nes_y_q;
`endif

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Raster timing generator clocked by the 25 MHz pixel clock from the pixel PLL. It qualifies the PLL `locked` flag, then produces 640x480@60 Hz sync, data-enable and pixel coordinates for the video output path. The NES picture renderer and the DAC/HDMI encoder consume these coordinates and syncs.

## Interface
Parameters:
- `H_ACTIVE`, 640: visible pixels per line
- `H_FRONT`, 16: horizontal front porch (pixels)
- `H_SYNC`, 96: hsync width (pixels)
- `H_BACK`, 48: horizontal back porch (pixels)
- `V_ACTIVE`, 480: visible lines
- `V_FRONT`, 10: vertical front porch (lines)
- `V_SYNC`, 2: vsync width (lines)
- `V_BACK`, 33: vertical back porch (lines)
- `SYNC_POL`, 0: sync active level (0 = active-low)
- `SETTLE_CYCLES`, 1024: clocks `locked` must stay high before raster starts

Ports:
- `clk`  in  1  pixel clock (25 MHz PLL output)
- `rst`  in  1  asynchronous, active-high reset
- `pll_locked`  in  1  PLL locked flag, treated as asynchronous
- `hsync`  out  1  horizontal sync, level per `SYNC_POL`
- `vsync`  out  1  vertical sync, level per `SYNC_POL`
- `de`  out  1  visible-area data enable
- `x`  out  10  pixel column; valid when `de`
- `y`  out  10  pixel row; valid when `de`
- `line_start`  out  1  one-cycle pulse at x=0 of each visible line
- `frame_start`  out  1  one-cycle pulse at x=0,y=0
- `running`  out  1  high while in RUN

## Operation
- `pll_locked` passes through a 2-flop synchronizer to give `lock_s`. Both flops reset to 0.
- State machine:
  - WAIT_LOCK: reset state. Go to SETTLE when `lock_s`=1.
  - SETTLE: a 16-bit counter counts clocks.
    - Go to WAIT_LOCK if `lock_s`=0.
    - Go to RUN when the counter reaches `SETTLE_CYCLES`-1.
  - RUN: h/v counters advance. Go to WAIT_LOCK on the first cycle that `lock_s`=0.
- Counters, both 10 bits unsigned:
  - `h_cnt` counts 0..H_TOTAL-1, where H_TOTAL = sum of the H_* parameters (800).
  - `v_cnt` increments when `h_cnt` wraps, counting 0..V_TOTAL-1 (525).
  - Both wrap to 0 together at end of frame.
  - Both are held at 0 outside RUN.
- Decode from the counter values:
  - `de` = `h_cnt`<H_ACTIVE and `v_cnt`<V_ACTIVE.
  - hsync active for `h_cnt` in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC).
  - vsync active for `v_cnt` in [V_ACTIVE+V_FRONT, V_ACTIVE+V_FRONT+V_SYNC). vsync is a whole-line quantity.
  - `x`/`y` = `h_cnt`/`v_cnt`, forced to 0 when `de`=0.
- Outside RUN all outputs hold their reset values.

## Timing
- Reset values: `hsync`=`vsync`=~`SYNC_POL` (inactive), `de`=0, `x`=0, `y`=0, `line_start`=0, `frame_start`=0, `running`=0.
- All outputs are registered and mutually aligned: 1 clock after the counter state they decode.
- Start-up latency:
  - `pll_locked` rising to SETTLE entry: 2 clocks (synchronizer).
  - SETTLE lasts exactly `SETTLE_CYCLES` clocks.
  - The first `frame_start` (with `de`=1, x=0, y=0) appears 1 clock after RUN entry.
- Frame period is 420000 clocks. `frame_start` and `line_start` coincide on the first pixel of each frame.
- Lock loss in RUN, at any position in the frame:
  - `lock_s` falls 2 clocks after `pll_locked`.
  - The next clock edge enters WAIT_LOCK and outputs return to reset values 1 clock later. No partial line is completed.
- Lock glitch during SETTLE restarts qualification from WAIT_LOCK. The settle count is not resumed.
- `rst` mid-frame forces reset values immediately (asynchronously).

## Configuration
- `VGA_NES_WINDOW_EN`: when defined, adds three outputs, registered and aligned with `de`:
  - `nes_de` (1 bit): high for x in 64..575 and `de`=1 (2x-scaled 256x240 window, horizontally centred).
  - `nes_x` (8 bits) = (x-64)>>1.
  - `nes_y` (8 bits) = y>>1.
  - `nes_x`/`nes_y` are 0 when `nes_de`=0; all three reset to 0.
- Without the macro these ports and their logic do not exist. Remaining behaviour is identical.

## Test plan
- Assert `rst` with `pll_locked`=1 -> all outputs at reset values. Release `rst` -> `running` rises 2+1024 clocks later (±1 for edge alignment), `frame_start` 1 clock after that.
- In RUN, measure one line:
  - `de` high for 640 clocks.
  - `hsync` low from 656 to 751 clocks after `line_start`.
  - `line_start` period 800 clocks.
- Measure a frame:
  - `frame_start` period 420000 clocks.
  - `vsync` low for exactly 1600 clocks, beginning at the start of line 490.
  - 480 `line_start` pulses per frame.
- Drop `pll_locked` at x=300,y=200 -> within 4 clocks `running`=0, `de`=0, syncs inactive. Re-raise -> full 1024-cycle settle repeats.
- Pulse `pll_locked` low for 1 clock at settle count 500 -> no RUN entry until a fresh 1024-cycle settle completes.
- With `VGA_NES_WINDOW_EN` defined, at x=64,y=0 -> `nes_de`=1, `nes_x`=0, `nes_y`=0. At x=575,y=479 -> `nes_x`=255, `nes_y`=239. At x=63 or x=576 -> `nes_de`=0.
